// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store path and a host burst port.
// Optional DMEM_ARB_STATS_EN adds saturating stall / host-wait counters.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_loadEn,
  input  logic          cpu_storEn,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_storData,
  output logic [7:0]    cpu_loadData,
  output logic          cpu_stall,
  input  logic          host_start,
  input  logic          host_we,
  input  logic [AW-1:0] host_base,
  input  logic [AW-1:0] host_len,
  input  logic [7:0]    host_wdata,
  output logic          host_beat,
  output logic [7:0]    host_rdata,
  output logic          host_busy,
  output logic          host_done,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   cpu_stall_cnt,
  output logic [15:0]   host_wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d;
  logic          we_q, we_d;
  logic [3:0]    starve_q, starve_d;

  logic cpu_req, starved, host_win, cpu_go, accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    idx_d        = idx_q;
    we_d         = we_q;
    starve_d     = starve_q;
    cpu_loadData = '0;
    host_beat    = 1'b0;
    host_rdata   = '0;
    host_busy    = 1'b0;
    host_done    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    accept       = 1'b0;

    cpu_req   = cpu_loadEn | cpu_storEn;
    starved   = (starve_q == 4'(MAX_WAIT));
    host_win  = (state_q == BURST) && (!cpu_req || starved);
    cpu_stall = host_win && cpu_req;
    cpu_go    = cpu_req && !cpu_stall;

    case (state_q)
      IDLE: begin
        if (host_start) begin
          accept   = 1'b1;
          base_d   = host_base;
          len_d    = host_len;
          we_d     = host_we;
          idx_d    = '0;
          starve_d = '0;
          state_d  = BURST;
        end
      end
      BURST: begin
        host_busy = 1'b1;
        if (host_win) begin
          host_beat = 1'b1;
          starve_d  = '0;
          idx_d     = idx_q + AW'(1);
          // len 0 wraps len-1 to all ones, giving a full 2**AW-beat burst
          if (idx_q == len_q - AW'(1)) state_d = DONE;
        end else begin
          starve_d = starve_q + 4'd1;
        end
      end
      DONE: begin
        host_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (host_win) begin
      mem_addr   = base_q + idx_q;
      mem_we     = we_q;
      mem_wdata  = we_q ? host_wdata : 8'h00;
      host_rdata = we_q ? 8'h00 : mem_rdata;
    end else if (cpu_go) begin
      mem_addr     = cpu_addr;
      mem_we       = cpu_storEn;
      mem_wdata    = cpu_storEn ? cpu_storData : 8'h00;
      cpu_loadData = cpu_loadEn ? mem_rdata : 8'h00;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, wait_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else if (accept) begin
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (cpu_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (state_q == BURST && !host_win && wait_cnt_q != 16'hFFFF)
        wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign cpu_stall_cnt = stall_cnt_q;
  assign host_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x8 data memory between the CPU load/store path and a host burst port.
- The host port is used by the testbench/loader to preload operands and read back results.
- Sits between the CPU core (address select, loadEn/storEn) and data_memory.
- CPU has per-cycle priority. A starvation counter guarantees host progress during long CPU memory phases.

Parameters:
- MAX_WAIT, 4: consecutive host beats the CPU may block before the host is forced a cycle (range 1..15).
- AW, 8: memory address width; depth = 2**AW.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_loadEn  in  1  CPU read request this cycle
- cpu_storEn  in  1  CPU write request this cycle
- cpu_addr  in  AW  CPU address (a or b register)
- cpu_storData  in  8  CPU write data
- cpu_loadData  out  8  CPU read data, combinational from mem_rdata
- cpu_stall  out  1  CPU access not performed this cycle; CPU holds request and PC
- host_start  in  1  start burst; sampled in IDLE only
- host_we  in  1  burst direction, 1 = write
- host_base  in  AW  burst start address
- host_len  in  AW  beat count; 0 encodes 2**AW
- host_wdata  in  8  write data for current beat
- host_beat  out  1  a host beat was performed this cycle (write data consumed / read data valid)
- host_rdata  out  8  read data, valid when host_beat & ~we_q
- host_busy  out  1  burst in progress
- host_done  out  1  one-cycle pulse after the last beat
- mem_addr  out  AW  to data_memory
- mem_wdata  out  8  to data_memory
- mem_we  out  1  write strobe, write committed at clk edge
- mem_rdata  in  8  combinational read data from data_memory

Behaviour:
- All registered state resets to zero and the FSM resets to IDLE. In IDLE with no CPU request, all outputs are 0.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - CPU has exclusive access.
  - host_start=1 latches base, len, and we_q; clears idx and starve_cnt; moves to BURST next cycle.
  - CPU accesses in the same cycle proceed normally.
- BURST:
  - host_busy=1.
  - cpu_req = cpu_loadEn | cpu_storEn.
  - Host wins when ~cpu_req, or when starve_cnt == MAX_WAIT.
  - CPU win: the CPU access is performed; starve_cnt++; no host beat.
  - Host win:
    - mem_addr = base_q + idx, mod 2**AW (wraps 0xFF -> 0x00).
    - On a write burst, mem_we=1 with host_wdata; otherwise host_rdata = mem_rdata.
    - host_beat=1; starve_cnt cleared; idx++.
    - If cpu_req was asserted, cpu_stall=1 this cycle.
  - After the beat where idx == len-1 (len 0 = 256 beats) -> DONE.
- DONE: host_done=1 for exactly one cycle; host_busy=0; -> IDLE. A host_start in DONE is ignored.
- host_start in BURST or DONE is ignored. No queueing.
- CPU access path:
  - mem_addr = cpu_addr.
  - cpu_storEn drives mem_we=1 with cpu_storData.
  - cpu_loadData = mem_rdata, valid the same cycle when cpu_stall=0.
- If cpu_loadEn and cpu_storEn are both 1, the store wins.
- cpu_stall is combinational and depends only on state, starve_cnt, and cpu_req. It never asserts in IDLE or DONE.
- Reset mid-burst aborts immediately: no host_done pulse, no further mem_we. Memory contents already written are retained.
- Latency: one beat per host-won cycle. Minimum burst time = len + 2 cycles from host_start to host_done (IDLE sample, len beats, DONE).

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output port cpu_stall_cnt (16 bits): saturating count of cycles with cpu_stall=1.
  - Adds output port host_wait_cnt (16 bits): saturating count of BURST cycles lost to the CPU.
  - Both counters clear on reset and on host_start acceptance.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Host write burst, CPU idle: base=0x10, len=4, wdata 0xA1..0xA4. Required: host_beat on 4 consecutive cycles, host_done 6 cycles after start, mem[0x10..0x13]=A1..A4, cpu_stall never 1.
2. Host read wrap: mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33; base=0xFE, len=3. Required: host_rdata 0x11, 0x22, 0x33 in order.
3. Starvation (MAX_WAIT=4): CPU holds cpu_loadEn continuously through a len=2 read burst. Required:
   - CPU served 4 cycles, then stalled 1 (host beat).
   - CPU served 4 more cycles, then stalled 1.
   - host_done follows.
4. Simultaneous loadEn+storEn, addr 0x05, data 0x7E, in IDLE. Required: mem_we=1 and mem[0x05]=0x7E.
5. len=0 write burst. Required: exactly 256 beats, then host_done. A host_start pulsed mid-burst is ignored.
6. Reset asserted after beat 2 of a len=8 write burst. Required: outputs 0 immediately, no host_done, only 2 locations written, FSM in IDLE after release.
